// File: rtl/dmac_axi_pkg.sv
// Shared AXI constants, FSM state types and the burst error classifier
// for the DMA controller's responder memory.
package dmac_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [2:0] SIZE_4B = 3'b010;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_DATA
   } rd_state_t;

   // Address outside the array wins over unsupported size/burst encodings.
   function automatic logic [1:0] burst_err(
      input logic [31:0] addr,
      input logic [2:0]  size,
      input logic [1:0]  burst,
      input int unsigned mem_aw
   );
      logic [31:0] hi_mask;
      hi_mask = ~((32'd1 << (mem_aw + 32'd2)) - 32'd1);
      if ((addr & hi_mask) != 32'd0) return RESP_DECERR;
      if ((size != SIZE_4B) || burst[1]) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word-addressed RAM: byte-enabled write port and registered read port.
// Only the read data register is reset; the array contents never are.
module axi_mem_array #(
   parameter int unsigned MEM_AW = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [MEM_AW-1:0] waddr_i,
   input  logic [31:0]       wdata_i,
   input  logic [3:0]        wstrb_i,
   input  logic              re_i,
   input  logic [MEM_AW-1:0] raddr_i,
   output logic [31:0]       rdata_o
);
   localparam int unsigned DEPTH = 1 << MEM_AW;

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   // A same-cycle write to raddr_i is not visible here: the old word is captured.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= 32'd0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI responder memory: independent write (AW/W/B) and read (AR/R) FSMs.
//   state  | meaning
//   W_IDLE | awready high, waiting for a write burst
//   W_DATA | wready high, committing beats until wlast
//   W_RESP | bvalid high with bresp held until bready
//   R_IDLE | arready high, waiting for a read burst
//   R_WAIT | counting down the read latency, then first capture
//   R_DATA | rvalid high, next word captured on each non-last handshake
module axi_mem_responder
   import dmac_axi_pkg::*;
#(
   parameter int unsigned MEM_AW = 10,
   parameter int unsigned RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] awaddr_i,
   input  logic [3:0]  awlen_i,
   input  logic [2:0]  awsize_i,
   input  logic [1:0]  awburst_i,
   input  logic        awvalid_i,
   output logic        awready_o,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   input  logic        wlast_i,
   input  logic        wvalid_i,
   output logic        wready_o,
   output logic [1:0]  bresp_o,
   output logic        bvalid_o,
   input  logic        bready_i,
   input  logic [31:0] araddr_i,
   input  logic [3:0]  arlen_i,
   input  logic [2:0]  arsize_i,
   input  logic [1:0]  arburst_i,
   input  logic        arvalid_i,
   output logic        arready_o,
   output logic [31:0] rdata_o,
   output logic [1:0]  rresp_o,
   output logic        rlast_o,
   output logic        rvalid_o,
   input  logic        rready_i
);
   localparam logic [MEM_AW-1:0] IDX_ONE  = MEM_AW'(1);
   localparam logic [3:0]        RD_LAT_C = 4'(RD_LAT);

   // Holds both address-ready outputs low for the first cycle after reset release.
   logic              rdy_en_q;

   wr_state_t         wr_state_q, wr_state_d;
   logic [MEM_AW-1:0] wr_idx_q, wr_idx_d;
   logic [3:0]        wr_len_q, wr_len_d;
   logic [1:0]        wr_burst_q, wr_burst_d;
   logic [1:0]        wr_err_q, wr_err_d;
   logic [4:0]        wr_beat_q, wr_beat_d;
   logic [1:0]        bresp_q, bresp_d;

   rd_state_t         rd_state_q, rd_state_d;
   logic [MEM_AW-1:0] rd_idx_q, rd_idx_d;
   logic [3:0]        rd_len_q, rd_len_d;
   logic [1:0]        rd_burst_q, rd_burst_d;
   logic [1:0]        rd_err_q, rd_err_d;
   logic [3:0]        rd_beat_q, rd_beat_d;
   logic [3:0]        rd_cnt_q, rd_cnt_d;

   logic              mem_we;
   logic              mem_re;
   logic [MEM_AW-1:0] mem_raddr;
   logic [31:0]       mem_rdata;

   axi_mem_array #(
      .MEM_AW(MEM_AW)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (mem_we),
      .waddr_i (wr_idx_q),
      .wdata_i (wdata_i),
      .wstrb_i (wstrb_i),
      .re_i    (mem_re),
      .raddr_i (mem_raddr),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      wr_state_d = wr_state_q;
      wr_idx_d   = wr_idx_q;
      wr_len_d   = wr_len_q;
      wr_burst_d = wr_burst_q;
      wr_err_d   = wr_err_q;
      wr_beat_d  = wr_beat_q;
      bresp_d    = bresp_q;
      mem_we     = 1'b0;
      awready_o  = 1'b0;
      wready_o   = 1'b0;
      bvalid_o   = 1'b0;
      unique case (wr_state_q)
         W_IDLE: begin
            awready_o = rdy_en_q;
            if (rdy_en_q && awvalid_i) begin
               wr_idx_d   = awaddr_i[MEM_AW+1:2];
               wr_len_d   = awlen_i;
               wr_burst_d = awburst_i;
               wr_err_d   = burst_err(awaddr_i, awsize_i, awburst_i, MEM_AW);
               wr_beat_d  = 5'd0;
               wr_state_d = W_DATA;
            end
         end
         W_DATA: begin
            wready_o = 1'b1;
            if (wvalid_i) begin
               mem_we = (wr_err_q == RESP_OKAY);
               if (wr_burst_q == BURST_INCR) wr_idx_d = wr_idx_q + IDX_ONE;
               // Saturate so an overlong burst can never alias back to awlen.
               if (wr_beat_q != 5'h1f) wr_beat_d = wr_beat_q + 5'd1;
               if (wlast_i) begin
                  if (wr_err_q != RESP_OKAY) begin
                     bresp_d = wr_err_q;
                  end else if (wr_beat_q != {1'b0, wr_len_q}) begin
                     bresp_d = RESP_SLVERR;
                  end else begin
                     bresp_d = RESP_OKAY;
                  end
                  wr_state_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            bvalid_o = 1'b1;
            if (bready_i) wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_idx_d   = rd_idx_q;
      rd_len_d   = rd_len_q;
      rd_burst_d = rd_burst_q;
      rd_err_d   = rd_err_q;
      rd_beat_d  = rd_beat_q;
      rd_cnt_d   = rd_cnt_q;
      mem_re     = 1'b0;
      mem_raddr  = rd_idx_q;
      arready_o  = 1'b0;
      rvalid_o   = 1'b0;
      unique case (rd_state_q)
         R_IDLE: begin
            arready_o = rdy_en_q;
            if (rdy_en_q && arvalid_i) begin
               rd_idx_d   = araddr_i[MEM_AW+1:2];
               rd_len_d   = arlen_i;
               rd_burst_d = arburst_i;
               rd_err_d   = burst_err(araddr_i, arsize_i, arburst_i, MEM_AW);
               rd_beat_d  = 4'd0;
               rd_cnt_d   = RD_LAT_C;
               rd_state_d = R_WAIT;
            end
         end
         R_WAIT: begin
            if (rd_cnt_q == 4'd0) begin
               mem_re     = 1'b1;
               rd_state_d = R_DATA;
            end else begin
               rd_cnt_d = rd_cnt_q - 4'd1;
            end
         end
         R_DATA: begin
            rvalid_o = 1'b1;
            if (rready_i) begin
               if (rd_beat_q == rd_len_q) begin
                  rd_state_d = R_IDLE;
               end else begin
                  if (rd_burst_q == BURST_INCR) rd_idx_d = rd_idx_q + IDX_ONE;
                  mem_raddr = rd_idx_d;
                  mem_re    = 1'b1;
                  rd_beat_d = rd_beat_q + 4'd1;
               end
            end
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdy_en_q   <= 1'b0;
         wr_state_q <= W_IDLE;
         wr_idx_q   <= '0;
         wr_len_q   <= 4'd0;
         wr_burst_q <= BURST_FIXED;
         wr_err_q   <= RESP_OKAY;
         wr_beat_q  <= 5'd0;
         bresp_q    <= RESP_OKAY;
      end else begin
         rdy_en_q   <= 1'b1;
         wr_state_q <= wr_state_d;
         wr_idx_q   <= wr_idx_d;
         wr_len_q   <= wr_len_d;
         wr_burst_q <= wr_burst_d;
         wr_err_q   <= wr_err_d;
         wr_beat_q  <= wr_beat_d;
         bresp_q    <= bresp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state_q <= R_IDLE;
         rd_idx_q   <= '0;
         rd_len_q   <= 4'd0;
         rd_burst_q <= BURST_FIXED;
         rd_err_q   <= RESP_OKAY;
         rd_beat_q  <= 4'd0;
         rd_cnt_q   <= 4'd0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_idx_q   <= rd_idx_d;
         rd_len_q   <= rd_len_d;
         rd_burst_q <= rd_burst_d;
         rd_err_q   <= rd_err_d;
         rd_beat_q  <= rd_beat_d;
         rd_cnt_q   <= rd_cnt_d;
      end
   end

   // Errored bursts return zero data regardless of what the array holds.
   assign rdata_o = (rd_err_q == RESP_OKAY) ? mem_rdata : 32'd0;
   assign rresp_o = rd_err_q;
   assign rlast_o = rvalid_o && (rd_beat_q == rd_len_q);
   assign bresp_o = bresp_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Self-checking bench for axi_mem_responder against a word-array reference model.
module tb_axi_mem_responder;

   localparam int unsigned MEM_AW = 10;
   localparam int unsigned RD_LAT = 1;
   localparam int          DEPTH  = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] awaddr_i, araddr_i, wdata_i, rdata_o;
   logic [3:0]  awlen_i, arlen_i, wstrb_i;
   logic [2:0]  awsize_i, arsize_i;
   logic [1:0]  awburst_i, arburst_i, bresp_o, rresp_o;
   logic        awvalid_i, awready_o, wlast_i, wvalid_i, wready_o;
   logic        bvalid_o, bready_i, arvalid_i, arready_o;
   logic        rlast_o, rvalid_o, rready_i;

   axi_mem_responder #(.MEM_AW(MEM_AW), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst),
      .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i), .awburst_i(awburst_i),
      .awvalid_i(awvalid_i), .awready_o(awready_o),
      .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
      .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
      .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i), .arburst_i(arburst_i),
      .arvalid_i(arvalid_i), .arready_o(arready_o),
      .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o), .rready_i(rready_i)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   logic [31:0] model_mem [DEPTH];
   logic [31:0] wbuf_data [64];
   logic [3:0]  wbuf_strb [64];
   logic [31:0] rbuf_data [64];
   logic [1:0]  rbuf_resp [64];
   logic        rbuf_last [64];
   int          rbuf_n, first_lat, hold_changes;
   logic [31:0] exp_data  [64];
   logic [1:0]  exp_rr;

   // ---------------- reference model ----------------
   function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [2:0] size,
                                           input logic [1:0] burst);
      if (addr >= 32'h0000_1000) return 2'b11;
      if (size != 3'd2 || burst == 2'b10 || burst == 2'b11) return 2'b10;
      return 2'b00;
   endfunction

   function automatic int beat_idx(input logic [31:0] addr, input logic [1:0] burst, input int i);
      int base;
      base = int'(addr[11:2]);
      return (burst == 2'b00) ? base : (base + i) % DEPTH;
   endfunction

   function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input int nbeats);
      logic [1:0] c;
      int idx;
      c = exp_resp(addr, size, burst);
      if (c != 2'b00) return c;
      for (int i = 0; i < nbeats; i++) begin
         idx = beat_idx(addr, burst, i);
         for (int b = 0; b < 4; b++)
            if (wbuf_strb[i][b]) model_mem[idx][8*b +: 8] = wbuf_data[i][8*b +: 8];
      end
      return (nbeats == int'(len) + 1) ? 2'b00 : 2'b10;
   endfunction

   function automatic void model_read(input logic [31:0] addr, input logic [3:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
      exp_rr = exp_resp(addr, size, burst);
      for (int i = 0; i <= int'(len); i++)
         exp_data[i] = (exp_rr == 2'b00) ? model_mem[beat_idx(addr, burst, i)] : 32'h0;
   endfunction

   // ---------------- bus drivers ----------------
   task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input int nbeats, input int b_delay,
                            output logic [1:0] resp);
      int n;
      logic got;
      resp = 2'bxx;
      awaddr_i = addr; awlen_i = len; awsize_i = size; awburst_i = burst; awvalid_i = 1'b1;
      n = 0;
      do begin got = awready_o; @(posedge clk); #1; n++; end while (!got && n < 200);
      awvalid_i = 1'b0;
      if (!got) begin errors++; $display("FAIL aw_timeout: awready %b, required 1", got); return; end
      for (int i = 0; i < nbeats; i++) begin
         wdata_i = wbuf_data[i]; wstrb_i = wbuf_strb[i]; wlast_i = (i == nbeats - 1); wvalid_i = 1'b1;
         n = 0;
         do begin got = wready_o; @(posedge clk); #1; n++; end while (!got && n < 200);
         if (!got) begin
            wvalid_i = 1'b0; errors++;
            $display("FAIL w_timeout: wready %b, required 1", got); return;
         end
      end
      wvalid_i = 1'b0; wlast_i = 1'b0;
      repeat (b_delay) begin @(posedge clk); #1; end
      bready_i = 1'b1;
      n = 0;
      do begin got = bvalid_o; resp = bresp_o; @(posedge clk); #1; n++; end while (!got && n < 200);
      bready_i = 1'b0;
      if (!got) begin errors++; $display("FAIL b_timeout: bvalid %b, required 1", got); end
   endtask

   // mode 0: rready always high, 1: 1-0-0-1 pattern per valid cycle, 2: random
   task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input int mode);
      int n, cyc;
      logic got, r, held, done, hl;
      logic [31:0] hd;
      logic [1:0] hr;
      rbuf_n = 0; first_lat = -1; hold_changes = 0; held = 1'b0; done = 1'b0;
      for (int i = 0; i < 64; i++) begin rbuf_data[i] = 'x; rbuf_resp[i] = 'x; rbuf_last[i] = 1'bx; end
      araddr_i = addr; arlen_i = len; arsize_i = size; arburst_i = burst; arvalid_i = 1'b1;
      n = 0;
      do begin got = arready_o; @(posedge clk); #1; n++; end while (!got && n < 200);
      arvalid_i = 1'b0;
      if (!got) begin errors++; $display("FAIL ar_timeout: arready %b, required 1", got); return; end
      cyc = 0; n = 0;
      while (!done && n < 400) begin
         case (mode)
            0:       r = 1'b1;
            1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: r = 1'($urandom_range(0, 1));
         endcase
         rready_i = r;
         if (rvalid_o) begin
            if (first_lat < 0) first_lat = n;
            if (held && (rdata_o !== hd || rresp_o !== hr || rlast_o !== hl)) hold_changes++;
            if (r) begin
               if (rbuf_n < 64) begin
                  rbuf_data[rbuf_n] = rdata_o; rbuf_resp[rbuf_n] = rresp_o; rbuf_last[rbuf_n] = rlast_o;
               end
               rbuf_n++; held = 1'b0;
               if (rlast_o) done = 1'b1;
            end else begin
               held = 1'b1; hd = rdata_o; hr = rresp_o; hl = rlast_o;
            end
            cyc++;
         end
         @(posedge clk); #1; n++;
      end
      rready_i = 1'b0;
      if (!done) begin errors++; $display("FAIL r_timeout: rlast handshake %b, required 1", done); end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [1:0] resp;
      rst = 1'b1;
      awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
      wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
      araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0; arvalid_i = 1'b0; rready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if ({awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o} !== 6'b0 ||
          rdata_o !== 32'h0 || rresp_o !== 2'b00 || bresp_o !== 2'b00) begin
         errors++;
         $display("FAIL reset_outputs: got rdy/valid %b rdata %h rresp %b bresp %b, required all 0",
                  {awready_o, arready_o, wready_o, bvalid_o, rvalid_o, rlast_o}, rdata_o, rresp_o, bresp_o);
      end
      rst = 1'b0;
      vectors++;
      if ({awready_o, arready_o, bvalid_o, rvalid_o} !== 4'b0 || rdata_o !== 32'h0) begin
         errors++;
         $display("FAIL release_cycle: got aw/ar/b/r %b rdata %h, required 0000 0",
                  {awready_o, arready_o, bvalid_o, rvalid_o}, rdata_o);
      end
      @(posedge clk); #1;
      vectors++;
      if ({awready_o, arready_o} !== 2'b11) begin
         errors++; $display("FAIL ready_rise: got %b, required 11", {awready_o, arready_o});
      end
      // Known background so every later read has a defined expectation.
      for (int k = 0; k < 64; k++) begin
         for (int i = 0; i < 16; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
         void'(model_write(32'(k * 64), 4'd15, 3'd2, 2'b01, 16));
         axi_write(32'(k * 64), 4'd15, 3'd2, 2'b01, 16, 0, resp);
         vectors++;
         if (resp !== 2'b00) begin errors++; $display("FAIL fill_bresp[%0d]: got %b, required 00", k, resp); end
      end
   endtask

   task automatic test_incr_basic();
      logic [1:0] resp;
      for (int i = 0; i < 4; i++) begin wbuf_data[i] = 32'hA0 + 32'(i); wbuf_strb[i] = 4'hF; end
      void'(model_write(32'h100, 4'd3, 3'd2, 2'b01, 4));
      axi_write(32'h100, 4'd3, 3'd2, 2'b01, 4, 0, resp);
      vectors++;
      if (resp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b, required 00", resp); end
      axi_read(32'h100, 4'd3, 3'd2, 2'b01, 0);
      vectors++;
      if (rbuf_n !== 4) begin errors++; $display("FAIL incr_beats: got %0d, required 4", rbuf_n); end
      vectors++;
      if (first_lat !== 1 + int'(RD_LAT)) begin
         errors++; $display("FAIL incr_latency: got %0d, required %0d", first_lat, 1 + RD_LAT);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (rbuf_data[i] !== 32'hA0 + 32'(i) || rbuf_resp[i] !== 2'b00 || rbuf_last[i] !== (i == 3)) begin
            errors++;
            $display("FAIL incr_beat[%0d]: got %h/%b/%b, required %h/00/%b", i,
                     rbuf_data[i], rbuf_resp[i], rbuf_last[i], 32'hA0 + 32'(i), i == 3);
         end
      end
   endtask

   task automatic test_strobe_stall();
      logic [1:0] resp;
      wbuf_data[0] = 32'hFFFF_FFFF; wbuf_strb[0] = 4'hF;
      void'(model_write(32'h200, 4'd0, 3'd2, 2'b01, 1));
      axi_write(32'h200, 4'd0, 3'd2, 2'b01, 1, 0, resp);
      wbuf_data[0] = 32'h1122_3344; wbuf_strb[0] = 4'b0101;
      void'(model_write(32'h200, 4'd0, 3'd2, 2'b01, 1));
      axi_write(32'h200, 4'd0, 3'd2, 2'b01, 1, 0, resp);
      axi_read(32'h200, 4'd0, 3'd2, 2'b01, 0);
      vectors++;
      if (rbuf_data[0] !== 32'hFF22_FF44) begin
         errors++; $display("FAIL strobe_merge: got %h, required ff22ff44", rbuf_data[0]);
      end
      model_read(32'h100, 4'd3, 3'd2, 2'b01);
      axi_read(32'h100, 4'd3, 3'd2, 2'b01, 1);
      vectors++;
      if (rbuf_n !== 4 || hold_changes !== 0) begin
         errors++; $display("FAIL stall_hold: got beats %0d changes %0d, required 4 0", rbuf_n, hold_changes);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (rbuf_data[i] !== exp_data[i] || rbuf_last[i] !== (i == 3)) begin
            errors++; $display("FAIL stall_beat[%0d]: got %h/%b, required %h/%b", i,
                               rbuf_data[i], rbuf_last[i], exp_data[i], i == 3);
         end
      end
   endtask

   task automatic test_errors();
      logic [1:0] resp, er;
      for (int i = 0; i < 2; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
      er = model_write(32'h1000, 4'd1, 3'd2, 2'b01, 2);
      axi_write(32'h1000, 4'd1, 3'd2, 2'b01, 2, 0, resp);
      vectors++;
      if (resp !== er || resp !== 2'b11) begin errors++; $display("FAIL decerr_bresp: got %b, required 11", resp); end
      model_read(32'h0, 4'd1, 3'd2, 2'b01);
      axi_read(32'h0, 4'd1, 3'd2, 2'b01, 0);
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (rbuf_data[i] !== exp_data[i]) begin
            errors++; $display("FAIL decerr_nowrite[%0d]: got %h, required %h", i, rbuf_data[i], exp_data[i]);
         end
      end
      axi_read(32'h1000, 4'd1, 3'd2, 2'b01, 0);
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (rbuf_resp[i] !== 2'b11 || rbuf_data[i] !== 32'h0 || rbuf_last[i] !== (i == 1)) begin
            errors++; $display("FAIL decerr_read[%0d]: got %b/%h/%b, required 11/0/%b", i,
                               rbuf_resp[i], rbuf_data[i], rbuf_last[i], i == 1);
         end
      end
      axi_read(32'h100, 4'd2, 3'd1, 2'b01, 0);
      vectors++;
      if (rbuf_n !== 3) begin errors++; $display("FAIL slverr_beats: got %0d, required 3", rbuf_n); end
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (rbuf_resp[i] !== 2'b10 || rbuf_data[i] !== 32'h0) begin
            errors++; $display("FAIL slverr_read[%0d]: got %b/%h, required 10/0", i, rbuf_resp[i], rbuf_data[i]);
         end
      end
      er = model_write(32'h300, 4'd1, 3'd2, 2'b10, 2);
      axi_write(32'h300, 4'd1, 3'd2, 2'b10, 2, 0, resp);
      vectors++;
      if (resp !== er) begin errors++; $display("FAIL wrap_bresp: got %b, required %b", resp, er); end
      model_read(32'h300, 4'd1, 3'd2, 2'b01);
      axi_read(32'h300, 4'd1, 3'd2, 2'b01, 0);
      vectors++;
      if (rbuf_data[0] !== exp_data[0] || rbuf_data[1] !== exp_data[1]) begin
         errors++; $display("FAIL wrap_nowrite: got %h %h, required %h %h",
                            rbuf_data[0], rbuf_data[1], exp_data[0], exp_data[1]);
      end
   endtask

   task automatic test_wrap_and_wlast();
      logic [1:0] resp, er;
      for (int i = 0; i < 4; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
      void'(model_write(32'hFF8, 4'd3, 3'd2, 2'b01, 4));
      axi_write(32'hFF8, 4'd3, 3'd2, 2'b01, 4, 0, resp);
      axi_read(32'hFF8, 4'd1, 3'd2, 2'b01, 0);
      vectors++;
      if (rbuf_data[0] !== wbuf_data[0] || rbuf_data[1] !== wbuf_data[1]) begin
         errors++; $display("FAIL top_words: got %h %h, required %h %h",
                            rbuf_data[0], rbuf_data[1], wbuf_data[0], wbuf_data[1]);
      end
      axi_read(32'h0, 4'd1, 3'd2, 2'b01, 0);
      vectors++;
      if (rbuf_data[0] !== wbuf_data[2] || rbuf_data[1] !== wbuf_data[3]) begin
         errors++; $display("FAIL wrap_words: got %h %h, required %h %h",
                            rbuf_data[0], rbuf_data[1], wbuf_data[2], wbuf_data[3]);
      end
      // Short burst, long burst, then FIXED; each read back through the model.
      for (int s = 0; s < 3; s++) begin
         logic [31:0] a;
         logic [3:0]  l;
         logic [1:0]  bt;
         int          nb;
         a  = (s == 0) ? 32'h400 : (s == 1) ? 32'h500 : 32'h600;
         l  = (s == 0) ? 4'd3 : (s == 1) ? 4'd1 : 4'd2;
         nb = (s == 0) ? 2 : 3;
         bt = (s == 2) ? 2'b00 : 2'b01;
         for (int i = 0; i < 4; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
         er = model_write(a, l, 3'd2, bt, nb);
         axi_write(a, l, 3'd2, bt, nb, 0, resp);
         vectors++;
         if (resp !== er) begin errors++; $display("FAIL wlast_bresp[%0d]: got %b, required %b", s, resp, er); end
         model_read(a, 4'd3, 3'd2, 2'b01);
         axi_read(a, 4'd3, 3'd2, 2'b01, 0);
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rbuf_data[i] !== exp_data[i]) begin
               errors++; $display("FAIL wlast_data[%0d][%0d]: got %h, required %h", s, i, rbuf_data[i], exp_data[i]);
            end
         end
      end
   endtask

   task automatic test_overlap();
      logic [1:0] resp;
      logic       b_seen;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 2; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'hF; end
         void'(model_write(32'h700, 4'd1, 3'd2, 2'b01, 2));
         model_read(32'h100, 4'd3, 3'd2, 2'b01);
         b_seen = 1'b0;
         fork
            axi_write(32'h700, 4'd1, 3'd2, 2'b01, 2, (pass == 0) ? 40 : 0, resp);
            begin
               if (pass == 0) repeat (6) begin @(posedge clk); #1; end
               axi_read(32'h100, 4'd3, 3'd2, 2'b01, 0);
               b_seen = bvalid_o;
            end
         join
         vectors++;
         if (resp !== 2'b00) begin errors++; $display("FAIL overlap_bresp[%0d]: got %b, required 00", pass, resp); end
         if (pass == 0) begin
            vectors++;
            if (b_seen !== 1'b1) begin errors++; $display("FAIL overlap_bpending: got %b, required 1", b_seen); end
         end
         for (int i = 0; i < 4; i++) begin
            vectors++;
            if (rbuf_data[i] !== exp_data[i] || rbuf_last[i] !== (i == 3)) begin
               errors++; $display("FAIL overlap_rdata[%0d][%0d]: got %h, required %h", pass, i, rbuf_data[i], exp_data[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      int  n, beats;
      logic got;
      araddr_i = 32'h100; arlen_i = 4'd7; arsize_i = 3'd2; arburst_i = 2'b01; arvalid_i = 1'b1;
      n = 0;
      do begin got = arready_o; @(posedge clk); #1; n++; end while (!got && n < 200);
      arvalid_i = 1'b0;
      rready_i = 1'b1;
      beats = 0; n = 0;
      while (beats < 2 && n < 50) begin
         if (rvalid_o) beats++;
         @(posedge clk); #1; n++;
      end
      vectors++;
      if (beats !== 2 || rvalid_o !== 1'b1) begin
         errors++; $display("FAIL midread_setup: got beats %0d rvalid %b, required 2 1", beats, rvalid_o);
      end
      rst = 1'b1; rready_i = 1'b0;
      @(posedge clk); #1;
      vectors++;
      if ({rvalid_o, rlast_o, arready_o, awready_o, bvalid_o} !== 5'b0 || rdata_o !== 32'h0 || rresp_o !== 2'b00) begin
         errors++; $display("FAIL midread_reset: got v/l/ar/aw/b %b rdata %h, required 00000 0",
                            {rvalid_o, rlast_o, arready_o, awready_o, bvalid_o}, rdata_o);
      end
      rst = 1'b0;
      vectors++;
      if (arready_o !== 1'b0) begin errors++; $display("FAIL midread_release: got arready %b, required 0", arready_o); end
      @(posedge clk); #1;
      vectors++;
      if (arready_o !== 1'b1) begin errors++; $display("FAIL midread_arready: got %b, required 1", arready_o); end
      model_read(32'h100, 4'd3, 3'd2, 2'b01);
      axi_read(32'h100, 4'd3, 3'd2, 2'b01, 0);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (rbuf_data[i] !== exp_data[i]) begin
            errors++; $display("FAIL midread_after[%0d]: got %h, required %h", i, rbuf_data[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [3:0]  l;
      logic [2:0]  s;
      logic [1:0]  bt, er, resp;
      int          nb, sel;
      for (int t = 0; t < 40; t++) begin
         a = {20'h0, 12'($urandom)};
         if ($urandom_range(0, 7) == 0) a[$urandom_range(12, 31)] = 1'b1;
         l = 4'($urandom);
         s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
         sel = $urandom_range(0, 9);
         bt = (sel < 5) ? 2'b01 : (sel < 8) ? 2'b00 : (sel == 8) ? 2'b10 : 2'b11;
         nb = int'(l) + 1;
         if ($urandom_range(0, 7) == 0) nb = $urandom_range(1, int'(l) + 2);
         for (int i = 0; i < nb; i++) begin wbuf_data[i] = $urandom; wbuf_strb[i] = 4'($urandom); end
         er = model_write(a, l, s, bt, nb);
         axi_write(a, l, s, bt, nb, $urandom_range(0, 3), resp);
         vectors++;
         if (resp !== er) begin errors++; $display("FAIL rand_bresp[%0d]: got %b, required %b", t, resp, er); end
         model_read(a, l, s, bt);
         axi_read(a, l, s, bt, 2);
         vectors++;
         if (rbuf_n !== int'(l) + 1 || hold_changes !== 0) begin
            errors++; $display("FAIL rand_beats[%0d]: got %0d changes %0d, required %0d 0", t, rbuf_n, hold_changes, int'(l) + 1);
         end
         for (int i = 0; i <= int'(l); i++) begin
            vectors++;
            if (rbuf_data[i] !== exp_data[i] || rbuf_resp[i] !== exp_rr || rbuf_last[i] !== (i == int'(l))) begin
               errors++; $display("FAIL rand_beat[%0d][%0d]: got %h/%b/%b, required %h/%b/%b", t, i,
                                  rbuf_data[i], rbuf_resp[i], rbuf_last[i], exp_data[i], exp_rr, i == int'(l));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_incr_basic();
      test_strobe_stall();
      test_errors();
      test_wrap_and_wlast();
      test_overlap();
      test_reset_mid_read();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
